// File: rtl/param_serializer.sv
// Parallel-to-serial shifter for the UART TX path: accepts a DATA_W-bit word over
// valid/ready and emits one bit per SHIFT_EN strobe, supporting back-to-back words.
module param_serializer #(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              P_VALID,
  output logic              P_READY,
  input  logic              SHIFT_EN,
  output logic              SER_DATA,
  output logic              SER_BUSY,
  output logic              SER_DONE
);

  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              ser_data_q;
  logic              ser_done_q;

  logic              last_strobe;
  logic              accept;
  logic              first_bit;
  logic              next_bit;
  logic [DATA_W-1:0] shifted;

  // The consuming strobe on the last bit frees the slot in the same cycle, which is
  // what lets a waiting word be loaded with no idle gap.
  assign last_strobe = (state == SHIFT) && SHIFT_EN && (bit_cnt == LAST);
  assign P_READY     = (state == IDLE) || last_strobe;
  assign accept      = P_VALID && P_READY;

  assign first_bit = LSB_FIRST ? P_DATA[0] : P_DATA[DATA_W-1];
  assign next_bit  = LSB_FIRST ? shift_reg[1] : shift_reg[DATA_W-2];
  assign shifted   = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ser_data_q <= IDLE_LEVEL;
      ser_done_q <= 1'b0;
    end else begin
      ser_done_q <= last_strobe;
      if (accept) begin
        state      <= SHIFT;
        shift_reg  <= P_DATA;
        bit_cnt    <= '0;
        ser_data_q <= first_bit;
      end else if (state == SHIFT && SHIFT_EN) begin
        if (bit_cnt == LAST) begin
          state      <= IDLE;
          ser_data_q <= IDLE_LEVEL;
        end else begin
          bit_cnt    <= bit_cnt + CNT_W'(1);
          shift_reg  <= shifted;
          ser_data_q <= next_bit;
        end
      end
    end
  end

  assign SER_DATA = ser_data_q;
  assign SER_BUSY = (state == SHIFT);
  assign SER_DONE = ser_done_q;

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer: three parameterisations driven with directed
// and random words, checked cycle by cycle against a word/bit-index reference model.
module tb_param_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks        = 0;
  int fails         = 0;
  int lanesFinished = 0;

  task automatic checkOutput(input int laneId, input string name,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL lane%0d %s: got 0x%0h, expected 0x%0h", laneId, name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input int laneId, input string name);
    checks++;
    fails++;
    $display("[TB] FAIL lane%0d %s: timed out waiting, expected completion", laneId, name);
  endtask

  task automatic markDone();
    lanesFinished++;
  endtask

  // Bit idx of a word in transmission order, straight from the bit-order rule.
  function automatic logic expBit(input logic [31:0] w, input int idx, input int width,
                                  input bit lsbFirst);
    logic [31:0] t;
    t = w;
    return lsbFirst ? t[idx] : t[width-1-idx];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int          W        = (g == 1) ? 12 : 8;
    localparam bit          LSB      = (g == 0);
    localparam bit          IDLE     = (g != 1);
    localparam logic [31:0] DIR_WORD = (g == 1) ? 32'hA5C : 32'hD2;
    localparam logic [31:0] ALL_ONES = (32'h1 << W) - 32'h1;

    logic         rst;
    logic         p_valid;
    logic         p_ready;
    logic         shift_en;
    logic         ser_data;
    logic         ser_busy;
    logic         ser_done;
    logic [W-1:0] p_data;

    logic [31:0] wordQ[$];
    int          mode;
    int          strobeCnt;

    param_serializer #(
      .DATA_W    (W),
      .LSB_FIRST (LSB),
      .IDLE_LEVEL(IDLE)
    ) dut (
      .CLK     (clk),
      .RST     (rst),
      .P_DATA  (p_data),
      .P_VALID (p_valid),
      .P_READY (p_ready),
      .SHIFT_EN(shift_en),
      .SER_DATA(ser_data),
      .SER_BUSY(ser_busy),
      .SER_DONE(ser_done)
    );

    // Strobe pattern: continuous, one in four, or random.
    always @(posedge clk) begin
      #1;
      strobeCnt++;
      case (mode)
        0:       shift_en = 1'b1;
        1:       shift_en = (strobeCnt % 4 == 0);
        default: shift_en = ($urandom_range(0, 2) != 0);
      endcase
    end

    // Reference model: current word, index of the bit on the line, pending done/start.
    logic [31:0] curWord = '0;
    int          idx = 0;
    bit          active = 1'b0;
    bit          startDue = 1'b0;
    bit          doneDue = 1'b0;
    bit          prevRst = 1'b0;
    bit          expReady;

    always @(negedge clk) begin
      if (rst) begin
        if (prevRst) begin
          checkOutput(g, "reset ser_busy", 32'(ser_busy), 32'd0);
          checkOutput(g, "reset ser_done", 32'(ser_done), 32'd0);
          checkOutput(g, "reset ser_data", 32'(ser_data), 32'(IDLE));
        end
        active   = 1'b0;
        startDue = 1'b0;
        doneDue  = 1'b0;
        prevRst  = 1'b1;
      end else begin
        prevRst = 1'b0;
        if (startDue) begin
          startDue = 1'b0;
          checkOutput(g, "queued words", 32'(wordQ.size()), 32'd1);
          if (wordQ.size() > 0) begin
            curWord = wordQ.pop_front();
            active  = 1'b1;
            idx     = 0;
          end
        end
        checkOutput(g, "ser_done", 32'(ser_done), 32'(doneDue));
        doneDue = 1'b0;
        checkOutput(g, "ser_busy", 32'(ser_busy), 32'(active));
        checkOutput(g, "ser_data", 32'(ser_data),
                    32'(active ? expBit(curWord, idx, W, LSB) : IDLE));
        expReady = !active || (idx == W - 1 && shift_en);
        checkOutput(g, "p_ready", 32'(p_ready), 32'(expReady));
        if (active && shift_en) begin
          if (idx == W - 1) begin
            active  = 1'b0;
            doneDue = 1'b1;
          end else begin
            idx++;
          end
        end
        if (p_valid && expReady) startDue = 1'b1;
      end
    end

    task automatic sendWord(input logic [31:0] data, input bit drop);
      bit ok;
      ok      = 1'b0;
      p_data  = data[W-1:0];
      p_valid = 1'b1;
      for (int t = 0; t < 1000; t++) begin
        @(negedge clk);
        if (p_ready && !rst) begin
          wordQ.push_back(data & ALL_ONES);
          ok = 1'b1;
          break;
        end
      end
      if (!ok) reportTimeout(g, "accept");
      @(posedge clk);
      #1;
      if (drop) p_valid = 1'b0;
      p_data = W'($urandom);
    endtask

    task automatic waitIdle();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (!ser_busy && !ser_done && wordQ.size() == 0 && !startDue) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) reportTimeout(g, "idle");
      @(posedge clk);
      #1;
    endtask

    task automatic applyStimulus();
      rst       = 1'b1;
      p_valid   = 1'b1;
      p_data    = DIR_WORD[W-1:0];
      shift_en  = 1'b0;
      mode      = 0;
      strobeCnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      p_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      mode = 0;
      sendWord(DIR_WORD, 1'b1);
      waitIdle();
      mode = 1;
      sendWord(DIR_WORD, 1'b1);
      waitIdle();

      mode = 0;
      sendWord(32'hD2, 1'b0);
      sendWord(32'h0F, 1'b1);
      waitIdle();
      mode = 1;
      sendWord($urandom, 1'b0);
      sendWord($urandom, 1'b1);
      waitIdle();

      // Abort a word in flight, then confirm the next word restarts cleanly.
      mode = 0;
      sendWord(ALL_ONES, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sendWord(DIR_WORD, 1'b1);
      waitIdle();

      for (int n = 0; n < 40; n++) begin
        bit drop;
        mode = $urandom_range(0, 2);
        drop = ($urandom_range(0, 1) == 1);
        sendWord($urandom, drop);
        if (drop) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      p_valid = 1'b0;
      waitIdle();
      checkOutput(g, "final queue empty", 32'(wordQ.size()), 32'd0);
      $display("[TB] lane%0d finished (DATA_W=%0d LSB_FIRST=%0d IDLE_LEVEL=%0d)", g, W, LSB, IDLE);
      markDone();
    endtask

    initial applyStimulus();
  end

  initial begin
    for (int c = 0; c < 60000 && lanesFinished < 3; c++) @(posedge clk);
    if (lanesFinished < 3) reportTimeout(-1, "lanes finished");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
